// File: rtl/div_unit_pkg.sv
// Shared widths, FSM encodings and control constants for the multi-cycle divider.
// Also carries the EX-stage aluop codes that select DIV/DIVU.
package div_unit_pkg;

  localparam int RegBusW       = 32;
  localparam int DoubleRegBusW = 64;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

  localparam logic [5:0] DivIters = 6'd32;

  // Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
  function automatic logic [RegBusW-1:0] neg_if(input logic neg, input logic [RegBusW-1:0] v);
    return neg ? (~v + {{(RegBusW-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Restoring shift-subtract 32-bit divider for DIV/DIVU: one quotient bit per cycle on magnitudes,
// sign correction applied once on the way into END. result_o = {remainder, quotient}.
module div_unit
  import div_unit_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     signed_div_i,
  input  logic [RegBusW-1:0]       opdata1_i,
  input  logic [RegBusW-1:0]       opdata2_i,
  input  logic                     start_i,
  input  logic                     annul_i,
  output logic [DoubleRegBusW-1:0] result_o,
  output logic                     ready_o,
  output logic [1:0]               dbg_state_o
);

  // Handshake: start_i is held by EX until ready_o is seen; ready_o then stays high with a
  // stable result_o until start_i drops, after which the unit returns to FREE for one cycle.

  div_state_e                state_q, state_d;
  logic [RegBusW-1:0]        q_q, q_d;
  logic [RegBusW:0]          rem_q, rem_d;
  logic [RegBusW-1:0]        divisor_q, divisor_d;
  logic [5:0]                cnt_q, cnt_d;
  logic                      neg_quot_q, neg_quot_d;
  logic                      neg_rem_q, neg_rem_d;
  logic [DoubleRegBusW-1:0]  result_q, result_d;
  logic                      ready_q, ready_d;

  logic [RegBusW:0]          trial;
  logic [RegBusW:0]          diff;
  logic                      ge;
  logic                      rem_msb_unused;

  // Remainder always stays below the divisor, so its top bit never matters for the shift.
  assign trial          = {rem_q[RegBusW-1:0], q_q[RegBusW-1]};
  assign diff           = trial - {1'b0, divisor_q};
  assign ge             = (trial >= {1'b0, divisor_q});
  assign rem_msb_unused = rem_q[RegBusW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DivFree;
      q_q        <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      rem_q      <= rem_d;
      divisor_q  <= divisor_d;
      cnt_q      <= cnt_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    rem_d      = rem_q;
    divisor_d  = divisor_q;
    cnt_d      = cnt_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d    = DivOn;
            divisor_d  = neg_if(signed_div_i & opdata2_i[RegBusW-1], opdata2_i);
            q_d        = neg_if(signed_div_i & opdata1_i[RegBusW-1], opdata1_i);
            rem_d      = '0;
            cnt_d      = '0;
            neg_quot_d = signed_div_i & (opdata1_i[RegBusW-1] ^ opdata2_i[RegBusW-1]);
            neg_rem_d  = signed_div_i & opdata1_i[RegBusW-1];
          end
        end
      end

      DivByZero: begin
        state_d  = DivEnd;
        result_d = '0;
        ready_d  = DivResultReady;
      end

      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end else if (cnt_q != DivIters) begin
          q_d   = {q_q[RegBusW-2:0], ge};
          rem_d = ge ? diff : trial;
          cnt_d = cnt_q + 6'd1;
        end else begin
          state_d  = DivEnd;
          result_d = {neg_if(neg_rem_q, rem_q[RegBusW-1:0]), neg_if(neg_quot_q, q_q)};
          ready_d  = DivResultReady;
        end
      end

      DivEnd: begin
        if (start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end
      end

      default: begin
        state_d  = DivFree;
        ready_d  = DivResultNotReady;
        result_d = '0;
      end
    endcase
  end

  assign result_o    = result_q;
  assign ready_o     = ready_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboarded bench for div_unit: driver pushes expected {rem, quot} and latency per request,
// a negedge monitor pops and compares on each rising ready_o.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic [1:0]  dbg_state_o;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int          exp_lat_q[$];
  int          req_cyc_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: plain integer division on 64-bit values, truncating toward zero.
  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint na, nb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      na = $signed(a);
      nb = $signed(b);
    end else begin
      na = {32'd0, a};
      nb = {32'd0, b};
    end
    q = na / nb;
    r = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  // ---------------- monitor ----------------
  logic ready_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst && ready_o && !ready_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ready: got ready_o=1 with result 0x%0h, expected no result", result_o);
      end else begin
        logic [63:0] e;
        int          el, rc;
        e  = exp_q.pop_front();
        el = exp_lat_q.pop_front();
        rc = req_cyc_q.pop_front();
        check("result", result_o, e);
        check("latency", 64'(cyc - rc), 64'(el));
      end
    end
    ready_prev = ready_o;
  end

  // ---------------- driver tasks ----------------
  task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [63:0] e;
    int          k;
    e = ref_div(s, a, b);
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    exp_q.push_back(e);
    exp_lat_q.push_back((b == 32'd0) ? 2 : 34);
    req_cyc_q.push_back(cyc);
    @(negedge clk);
    // Operands after acceptance must not matter.
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom_range(0, 1));
    k = 0;
    while (!ready_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!ready_o) begin
      n_checks++;
      $display("FAIL ready_timeout: got no ready_o in 100 cycles, expected ready");
      exp_q.delete();
      exp_lat_q.delete();
      req_cyc_q.delete();
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_ready", 64'(ready_o), 64'd1);
        check("hold_result", result_o, e);
      end
    end
    start_i = 1'b0;
    @(negedge clk);
    check("drop_ready", 64'(ready_o), 64'd0);
    check("drop_result", result_o, 64'd0);
    check("drop_state", 64'(dbg_state_o), 64'(DivFree));
  endtask

  task automatic run_annul(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(negedge clk);  // after E0: cnt=0
    repeat (10) @(negedge clk);  // after E10: cnt=10
    check("annul_pre_state", 64'(dbg_state_o), 64'(DivOn));
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_state", 64'(dbg_state_o), 64'(DivFree));
    check("annul_ready", 64'(ready_o), 64'd0);
    check("annul_result", result_o, 64'd0);
  endtask

  task automatic run_reset_mid(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div_i = 1'b1;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    repeat (6) @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    check("rst_state", 64'(dbg_state_o), 64'(DivFree));
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_no_ready", 64'(ready_o), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a, b;
    int          k;
    rst = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 64'(dbg_state_o), 64'(DivFree));
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(ready_o), 64'd0);

    run_div(1'b0, 32'd100, 32'd7, 3);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    run_div(1'b1, 32'd5, 32'd0, 2);
    run_div(1'b0, 32'd5, 32'd0, 0);
    run_annul(32'd1234567, 32'd89);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(1'b1, 32'h8000_0000, 32'd1, 0);
    run_reset_mid(32'd999, 32'd3);
    run_div(1'b1, 32'hFFFF_FF00, 32'hFFFF_FFF0, 1);

    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 50));
      run_div(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 3));
    end

    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
